// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter feeding a single SPI master link (sclk/mosi/cs) to a
// DATA_W-bit LSB-first slave that needs a start pulse and a trailing done pulse.
module spi_master_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 12,
   parameter int CLK_DIV = 4,
   parameter int GUARD   = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] data_in,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      busy,
   output logic                      sclk,
   output logic                      mosi,
   output logic                      cs
);

   localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CMAX   = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
   localparam int CW     = $clog2(CMAX + 1);
   localparam int NPULSE = DATA_W + 2;
   localparam int PW     = $clog2(NPULSE);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_CLOCK, S_GUARD} state_t;

   state_t            state;
   logic [IW-1:0]     ptr;
   logic [DATA_W-1:0] shift;
   logic [CW-1:0]     div_cnt;
   logic [PW-1:0]     pcnt;

   logic [IW-1:0]     winner;
   logic              found;

   // Search starts just after the last winner, so the previous owner goes last.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ptr     <= IW'(NUM_REQ - 1);
         shift   <= '0;
         div_cnt <= '0;
         pcnt    <= '0;
         grant   <= '0;
         ack     <= '0;
         busy    <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         cs      <= 1'b1;
      end else begin
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  shift   <= data_in[winner*DATA_W +: DATA_W];
                  grant   <= NUM_REQ'(1) << winner;
                  ptr     <= winner;
                  cs      <= 1'b0;
                  mosi    <= 1'b0;
                  div_cnt <= '0;
                  pcnt    <= '0;
                  busy    <= 1'b1;
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (div_cnt == CW'(CLK_DIV - 1)) begin
                  div_cnt <= '0;
                  state   <= S_CLOCK;
               end else begin
                  div_cnt <= div_cnt + CW'(1);
               end
            end
            S_CLOCK: begin
               if (div_cnt == CW'(CLK_DIV - 1)) begin
                  div_cnt <= '0;
                  sclk    <= ~sclk;
                  // Falling edge: present the bit for the next pulse, or close the frame.
                  if (sclk) begin
                     if (pcnt == PW'(NPULSE - 1)) begin
                        cs    <= 1'b1;
                        mosi  <= 1'b0;
                        ack   <= grant;
                        grant <= '0;
                        state <= S_GUARD;
                     end else begin
                        pcnt  <= pcnt + PW'(1);
                        mosi  <= shift[0];
                        shift <= {1'b0, shift[DATA_W-1:1]};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + CW'(1);
               end
            end
            S_GUARD: begin
               if (div_cnt == CW'(GUARD - 1)) begin
                  div_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  div_cnt <= div_cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench: default instance (CLK_DIV=4) plus a CLK_DIV=1 instance, each
// observed by a small SPI slave model that records every cs-low frame.
module tb_spi_master_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  req_a = '0, req_b = '0;
   logic [47:0] data_a = '0, data_b = '0;
   logic [3:0]  grant_a, ack_a, grant_b, ack_b;
   logic        busy_a, sclk_a, mosi_a, cs_a;
   logic        busy_b, sclk_b, mosi_b, cs_b;

   spi_master_arbiter dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .data_in(data_a),
      .grant(grant_a), .ack(ack_a), .busy(busy_a),
      .sclk(sclk_a), .mosi(mosi_a), .cs(cs_a)
   );

   spi_master_arbiter #(.NUM_REQ(4), .DATA_W(12), .CLK_DIV(1), .GUARD(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .data_in(data_b),
      .grant(grant_b), .ack(ack_b), .busy(busy_b),
      .sclk(sclk_b), .mosi(mosi_b), .cs(cs_b)
   );

   typedef struct {
      logic [13:0] rx;
      int          pulses;
      int          cslow;
      int          gap;
      logic [3:0]  g;
      logic [3:0]  a;
   } frame_t;

   frame_t fq_a[$];
   frame_t fq_b[$];
   int errors = 0;
   int checks = 0;

   // Slave model A: LSB-first shift on sclk rise; rx[0] is pulse 1, rx[13] pulse 14.
   logic [13:0] rx_a = '0;
   int pc_a = 0, cslow_a = 0, gap_cnt_a = 0, gap_snap_a = 0;
   logic [3:0] g_a = '0;
   logic prev_cs_a = 1'b1;
   frame_t nf_a;
   always @(negedge cs_a) begin rx_a <= '0; pc_a <= 0; end
   always @(posedge sclk_a) if (cs_a === 1'b0) begin rx_a <= {mosi_a, rx_a[13:1]}; pc_a <= pc_a + 1; end
   always @(negedge clk) begin
      if (cs_a === 1'b0) begin
         if (prev_cs_a) begin cslow_a <= 1; g_a <= grant_a; gap_snap_a <= gap_cnt_a; end
         else cslow_a <= cslow_a + 1;
         gap_cnt_a <= 0;
      end else begin
         if (!prev_cs_a) begin
            nf_a.rx = rx_a; nf_a.pulses = pc_a; nf_a.cslow = cslow_a;
            nf_a.gap = gap_snap_a; nf_a.g = g_a; nf_a.a = ack_a;
            fq_a.push_back(nf_a);
         end
         gap_cnt_a <= gap_cnt_a + 1;
      end
      prev_cs_a <= (cs_a !== 1'b0);
   end

   // Slave model B for the fast instance.
   logic [13:0] rx_b = '0;
   int pc_b = 0, cslow_b = 0;
   logic [3:0] g_b = '0;
   logic prev_cs_b = 1'b1;
   frame_t nf_b;
   always @(negedge cs_b) begin rx_b <= '0; pc_b <= 0; end
   always @(posedge sclk_b) if (cs_b === 1'b0) begin rx_b <= {mosi_b, rx_b[13:1]}; pc_b <= pc_b + 1; end
   always @(negedge clk) begin
      if (cs_b === 1'b0) begin
         if (prev_cs_b) begin cslow_b <= 1; g_b <= grant_b; end
         else cslow_b <= cslow_b + 1;
      end else if (!prev_cs_b) begin
         nf_b.rx = rx_b; nf_b.pulses = pc_b; nf_b.cslow = cslow_b;
         nf_b.gap = 0; nf_b.g = g_b; nf_b.a = ack_b;
         fq_b.push_back(nf_b);
      end
      prev_cs_b <= (cs_b !== 1'b0);
   end

   task automatic wait_frame(input bit sel_b, output frame_t f, output bit ok);
      ok = 1'b0;
      f.rx = '0; f.pulses = 0; f.cslow = 0; f.gap = 0; f.g = '0; f.a = '0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         if (!sel_b && fq_a.size() > 0) begin f = fq_a.pop_front(); ok = 1'b1; break; end
         if (sel_b && fq_b.size() > 0) begin f = fq_b.pop_front(); ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL frame_timeout: got no frame, required one within 400 cycles");
      end else begin
         $display("frame dut=%s grant=%b ack=%b word=%h pulses=%0d cs_low=%0d gap=%0d",
                  sel_b ? "b" : "a", f.g, f.a, f.rx[12:1], f.pulses, f.cslow, f.gap);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cs_a, sclk_a, mosi_a, busy_a, grant_a, ack_a} !== 12'b1000_0000_0000) begin
         errors++;
         $display("FAIL reset_a: got cs,sclk,mosi,busy,grant,ack=%b required 100000000000",
                  {cs_a, sclk_a, mosi_a, busy_a, grant_a, ack_a});
      end
      checks++;
      if ({cs_b, sclk_b, mosi_b, busy_b, grant_b, ack_b} !== 12'b1000_0000_0000) begin
         errors++;
         $display("FAIL reset_b: got %b required 100000000000",
                  {cs_b, sclk_b, mosi_b, busy_b, grant_b, ack_b});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      frame_t f; bit ok;
      data_a[11:0] = 12'hA5C;
      req_a = 4'b0001;
      @(negedge clk);
      checks++;
      if ({cs_a, busy_a, grant_a} !== 6'b01_0001) begin
         errors++;
         $display("FAIL basic_start: got cs,busy,grant=%b required 010001", {cs_a, busy_a, grant_a});
      end
      wait_frame(1'b0, f, ok);
      req_a = 4'b0000;
      if (ok) begin
         checks++;
         if (f.rx[12:1] !== 12'hA5C) begin errors++; $display("FAIL basic_word: got %h required a5c", f.rx[12:1]); end
         checks++;
         if (f.pulses !== 14) begin errors++; $display("FAIL basic_pulses: got %0d required 14", f.pulses); end
         checks++;
         if (f.cslow !== 116) begin errors++; $display("FAIL basic_cs_low: got %0d required 116", f.cslow); end
         checks++;
         if ({f.rx[13], f.rx[0]} !== 2'b00) begin errors++; $display("FAIL basic_start_done_bits: got %b required 00", {f.rx[13], f.rx[0]}); end
         checks++;
         if (f.a !== 4'b0001) begin errors++; $display("FAIL basic_ack: got %b required 0001", f.a); end
      end
      @(negedge clk);
      checks++;
      if (ack_a !== 4'b0000) begin errors++; $display("FAIL basic_ack_width: got %b required 0000", ack_a); end
   endtask

   task automatic test_round_robin();
      frame_t f; bit ok;
      logic [11:0] words [4];
      logic [3:0] exp_g;
      words[0] = 12'h111; words[1] = 12'h2C2; words[2] = 12'h393; words[3] = 12'h4E4;
      do_reset();
      data_a = {words[3], words[2], words[1], words[0]};
      req_a = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_frame(1'b0, f, ok);
         if (k == 4) req_a = 4'b0000;
         if (ok) begin
            exp_g = 4'b0001 << (k % 4);
            checks++;
            if (f.g !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b required %b", k, f.g, exp_g); end
            checks++;
            if (f.a !== exp_g) begin errors++; $display("FAIL rr_ack%0d: got %b required %b", k, f.a, exp_g); end
            checks++;
            if (f.rx[12:1] !== words[k % 4]) begin errors++; $display("FAIL rr_word%0d: got %h required %h", k, f.rx[12:1], words[k % 4]); end
            if (k > 0) begin
               checks++;
               if (f.gap < 2) begin errors++; $display("FAIL rr_gap%0d: got %0d required >=2", k, f.gap); end
            end
         end
      end
   endtask

   task automatic test_rr_pointer();
      frame_t f; bit ok;
      do_reset();
      data_a = {12'h0F0, 12'h7A7, 12'h0B0, 12'h3D3};
      req_a = 4'b0100;
      wait_frame(1'b0, f, ok);
      req_a = 4'b0101;
      checks++;
      if (f.g !== 4'b0100) begin errors++; $display("FAIL ptr_first: got %b required 0100", f.g); end
      wait_frame(1'b0, f, ok);
      checks++;
      if (f.g !== 4'b0001 || f.rx[12:1] !== 12'h3D3) begin
         errors++; $display("FAIL ptr_second: got grant=%b word=%h required 0001/3d3", f.g, f.rx[12:1]);
      end
      wait_frame(1'b0, f, ok);
      req_a = 4'b0000;
      checks++;
      if (f.g !== 4'b0100 || f.rx[12:1] !== 12'h7A7) begin
         errors++; $display("FAIL ptr_third: got grant=%b word=%h required 0100/7a7", f.g, f.rx[12:1]);
      end
   endtask

   task automatic test_capture_hold();
      frame_t f; bit ok;
      data_a[11:0] = 12'h3C7;
      req_a = 4'b0001;
      repeat (30) @(negedge clk);
      data_a[11:0] = 12'h999;
      req_a = 4'b0000;
      wait_frame(1'b0, f, ok);
      checks++;
      if (f.rx[12:1] !== 12'h3C7) begin errors++; $display("FAIL capture_word: got %h required 3c7", f.rx[12:1]); end
      checks++;
      if (f.a !== 4'b0001) begin errors++; $display("FAIL capture_ack: got %b required 0001", f.a); end
   endtask

   task automatic test_reset_midframe();
      frame_t f; bit ok; bit hit;
      hit = 1'b0;
      data_a[11:0] = 12'h5A3;
      req_a = 4'b0001;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (pc_a == 7 && sclk_a === 1'b1) begin hit = 1'b1; break; end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL midrst_reach: got no pulse 7, required one"); end
      #2 rst_n = 1'b0;
      req_a = 4'b0000;
      #1;
      checks++;
      if ({cs_a, sclk_a, grant_a, ack_a, busy_a} !== 11'b10_0000_0000_0) begin
         errors++;
         $display("FAIL midrst_outputs: got cs,sclk,grant,ack,busy=%b required 10000000000",
                  {cs_a, sclk_a, grant_a, ack_a, busy_a});
      end
      wait_frame(1'b0, f, ok);
      checks++;
      if (f.a !== 4'b0000 || f.pulses !== 7) begin
         errors++; $display("FAIL midrst_abort: got ack=%b pulses=%0d required 0000/7", f.a, f.pulses);
      end
      @(negedge clk);
      rst_n = 1'b1;
      data_a[11:0] = 12'h6B1;
      req_a = 4'b0001;
      wait_frame(1'b0, f, ok);
      req_a = 4'b0000;
      checks++;
      if (f.rx[12:1] !== 12'h6B1 || f.a !== 4'b0001 || f.cslow !== 116) begin
         errors++;
         $display("FAIL midrst_recover: got word=%h ack=%b cs_low=%0d required 6b1/0001/116",
                  f.rx[12:1], f.a, f.cslow);
      end
   endtask

   task automatic test_fast_clock();
      frame_t f; bit ok;
      data_b[11:0] = 12'hFFF;
      req_b = 4'b0001;
      wait_frame(1'b1, f, ok);
      req_b = 4'b0000;
      checks++;
      if (f.cslow !== 29) begin errors++; $display("FAIL fast_cs_low: got %0d required 29", f.cslow); end
      checks++;
      if (f.rx !== 14'b0_1111_1111_1111_0) begin errors++; $display("FAIL fast_bits: got %b required 01111111111110", f.rx); end
      checks++;
      if (f.pulses !== 14 || f.a !== 4'b0001) begin
         errors++; $display("FAIL fast_pulses_ack: got %0d/%b required 14/0001", f.pulses, f.a);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_rr_pointer();
      test_capture_hold();
      test_reset_midframe();
      test_fast_clock();
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
